// File: rtl/dh_exchange_ctrl.sv
// rtl/dh_exchange_ctrl.sv - Diffie-Hellman exchange sequencer for a shared exponentiation engine.
// Runs g^a, g^b, B^a, A^b in turn, reducing each engine result modulo the latched p.
module dh_exchange_ctrl #(
  parameter int W       = 32,
  parameter int RW      = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          abort,
  input  logic [W-1:0]  g,
  input  logic [W-1:0]  p,
  input  logic [W-1:0]  priv_a,
  input  logic [W-1:0]  priv_b,
  output logic          exp_start,
  output logic [W-1:0]  exp_base,
  output logic [W-1:0]  exp_exponent,
  input  logic [RW-1:0] exp_result,
  input  logic          exp_done,
  output logic [W-1:0]  pub_a,
  output logic [W-1:0]  pub_b,
  output logic [W-1:0]  key_a,
  output logic [W-1:0]  key_b,
  output logic          match,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_FIN, S_ERR} state_t;

  state_t        state;
  logic [1:0]    job;
  logic [CW-1:0] cnt;
  logic [W-1:0]  g_l, p_l, a_l, b_l;
  logic [W-1:0]  reduced;

  // p_l is never zero while in RUN, the only state that consumes this.
  assign reduced = W'(exp_result % RW'(p_l));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      job          <= '0;
      cnt          <= '0;
      g_l          <= '0;
      p_l          <= '0;
      a_l          <= '0;
      b_l          <= '0;
      exp_start    <= 1'b0;
      exp_base     <= '0;
      exp_exponent <= '0;
      pub_a        <= '0;
      pub_b        <= '0;
      key_a        <= '0;
      key_b        <= '0;
      match        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over everything, including a same-cycle exp_done.
      if (abort && state != S_IDLE) begin
        state        <= S_IDLE;
        exp_start    <= 1'b0;
        exp_base     <= '0;
        exp_exponent <= '0;
        busy         <= 1'b0;
        cnt          <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go && !abort) begin
              g_l   <= g;
              p_l   <= p;
              a_l   <= priv_a;
              b_l   <= priv_b;
              pub_a <= '0;
              pub_b <= '0;
              key_a <= '0;
              key_b <= '0;
              match <= 1'b0;
              error <= 1'b0;
              job   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              if (p == '0) begin
                state <= S_ERR;
              end else begin
                state        <= S_RUN;
                exp_start    <= 1'b1;
                exp_base     <= g;
                exp_exponent <= priv_a;
              end
            end
          end
          S_RUN: begin
            if (exp_done) begin
              case (job)
                2'd0:    pub_a <= reduced;
                2'd1:    pub_b <= reduced;
                2'd2:    key_a <= reduced;
                default: key_b <= reduced;
              endcase
              cnt       <= '0;
              exp_start <= 1'b0;
              state     <= S_GAP;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
              cnt          <= '0;
              exp_start    <= 1'b0;
              exp_base     <= '0;
              exp_exponent <= '0;
              state        <= S_ERR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAP: begin
            // Hold off the next job until the engine has released exp_done.
            if (!exp_done) begin
              if (job == 2'd3) begin
                exp_base     <= '0;
                exp_exponent <= '0;
                state        <= S_FIN;
              end else begin
                job          <= job + 1'b1;
                exp_start    <= 1'b1;
                exp_base     <= (job == 2'd0) ? g_l : (job == 2'd1) ? pub_b : pub_a;
                exp_exponent <= (job == 2'd1) ? a_l : b_l;
                state        <= S_RUN;
              end
            end
          end
          S_FIN: begin
            match <= (key_a == key_b);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          S_ERR: begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// tb/tb_dh_exchange_ctrl.sv - self-checking bench for dh_exchange_ctrl with a behavioural engine.
module tb_dh_exchange_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] g = '0, p = '0, priv_a = '0, priv_b = '0;
  logic        exp_start;
  logic [31:0] exp_base, exp_exponent;
  logic [63:0] exp_result = '0;
  logic        exp_done = 1'b0;
  logic [31:0] pub_a, pub_b, key_a, key_b;
  logic        match, busy, done, error;

  int checks = 0;
  int failures = 0;

  dh_exchange_ctrl #(.W(32), .RW(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .g(g), .p(p), .priv_a(priv_a), .priv_b(priv_b),
    .exp_start(exp_start), .exp_base(exp_base), .exp_exponent(exp_exponent),
    .exp_result(exp_result), .exp_done(exp_done),
    .pub_a(pub_a), .pub_b(pub_b), .key_a(key_a), .key_b(key_b),
    .match(match), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modpow(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m);
    logic [63:0] r, x;
    if (m == 32'd1) return 32'd0;
    r = 64'd1;
    x = {32'd0, b} % {32'd0, m};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % {32'd0, m};
      x = (x * x) % {32'd0, m};
    end
    return r[31:0];
  endfunction

  // Engine model: answers after eng_lat cycles of exp_start, returns an
  // unreduced multiple-of-p offset result, and can hold exp_done or hang.
  int eng_lat = 10;
  int eng_hold = 0;
  bit eng_hang = 1'b0;
  int eng_cnt = 0;
  int eng_left = 0;
  int eng_jobs = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_done = 1'b0;
      eng_cnt = 0;
      eng_left = 0;
      prev_start = 1'b0;
    end else begin
      if (exp_start && !prev_start) eng_jobs++;
      prev_start = exp_start;
      if (exp_start) begin
        if (!exp_done) begin
          eng_cnt++;
          if (!eng_hang && eng_cnt >= eng_lat) begin
            exp_done = 1'b1;
            exp_result = {32'd0, modpow(exp_base, exp_exponent, p)} +
                         64'($urandom_range(0, 1 << 20)) * {32'd0, p};
            eng_left = eng_hold;
          end
        end
      end else begin
        eng_cnt = 0;
        if (exp_done) begin
          if (eng_left > 0) eng_left--;
          else exp_done = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic start_go(input logic [31:0] gg, input logic [31:0] pp,
                          input logic [31:0] aa, input logic [31:0] bb);
    g = gg; p = pp; priv_a = aa; priv_b = bb;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done_check(input string name, input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [31:0] eka, input logic [31:0] ekb, input logic em);
    bit seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk({name, ".done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, ".pub_a"}, pub_a, ea);
      chk({name, ".pub_b"}, pub_b, eb);
      chk({name, ".key_a"}, key_a, eka);
      chk({name, ".key_b"}, key_b, ekb);
      chk({name, ".match"}, match, em);
      chk({name, ".error"}, error, 1'b0);
      chk({name, ".busy"}, busy, 1'b0);
      tick();
      chk({name, ".done_single"}, done, 1'b0);
    end
  endtask

  task automatic run_model(input string name, input logic [31:0] gg, input logic [31:0] pp,
                           input logic [31:0] aa, input logic [31:0] bb);
    logic [31:0] ea, eb, eka, ekb;
    ea  = modpow(gg, aa, pp);
    eb  = modpow(gg, bb, pp);
    eka = modpow(eb, aa, pp);
    ekb = modpow(ea, bb, pp);
    start_go(gg, pp, aa, bb);
    wait_done_check(name, ea, eb, eka, ekb, eka == ekb);
  endtask

  typedef struct {
    logic [31:0] g, p, a, b;
    logic [31:0] pa, pb, ka, kb;
    logic        m;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, hc, lo;
    bit bad;
    tbl[0] = '{32'd5, 32'd23, 32'd6, 32'd15, 32'd8, 32'd19, 32'd2, 32'd2, 1'b1};
    tbl[1] = '{32'd2, 32'd11, 32'd3, 32'd4,  32'd8, 32'd5,  32'd4, 32'd4, 1'b1};
    tbl[2] = '{32'd3, 32'd7,  32'd0, 32'd5,  32'd1, 32'd5,  32'd1, 32'd1, 1'b1};
    tbl[3] = '{32'd4, 32'd1,  32'd2, 32'd3,  32'd0, 32'd0,  32'd0, 32'd0, 1'b1};

    // Reset state
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst.exp_start", exp_start, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.error", error, 1'b0);
    chk("rst.pub_a", pub_a, 32'd0);
    chk("rst.key_b", key_b, 32'd0);
    chk("rst.exp_base", exp_base, 32'd0);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      start_go(tbl[i].g, tbl[i].p, tbl[i].a, tbl[i].b);
      wait_done_check($sformatf("tbl%0d", i), tbl[i].pa, tbl[i].pb, tbl[i].ka, tbl[i].kb, tbl[i].m);
    end

    // p == 0: error two cycles after go, engine never started
    start_go(32'd5, 32'd0, 32'd6, 32'd15);
    chk("p0.busy_1", busy, 1'b1);
    chk("p0.error_1", error, 1'b0);
    chk("p0.start_1", exp_start, 1'b0);
    tick();
    chk("p0.error_2", error, 1'b1);
    chk("p0.busy_2", busy, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (exp_start || done) bad = 1'b1;
      tick();
    end
    chk("p0.no_start_no_done", 64'(bad), 64'd0);
    chk("p0.error_sticky", error, 1'b1);
    start_go(tbl[0].g, tbl[0].p, tbl[0].a, tbl[0].b);
    chk("p0.error_cleared", error, 1'b0);
    wait_done_check("p0_recover", tbl[0].pa, tbl[0].pb, tbl[0].ka, tbl[0].kb, 1'b1);

    // Timeout with a hung engine
    eng_hang = 1'b1;
    start_go(32'd5, 32'd23, 32'd6, 32'd15);
    hc = 0;
    bad = 1'b0;
    while (exp_start && hc < 100) begin
      hc++;
      tick();
    end
    chk("tmo.run_cycles", 64'(hc), 64'd16);
    tick();
    chk("tmo.error", error, 1'b1);
    chk("tmo.busy", busy, 1'b0);
    chk("tmo.start", exp_start, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (done) bad = 1'b1;
      tick();
    end
    chk("tmo.no_done", 64'(bad), 64'd0);
    eng_hang = 1'b0;

    // Abort during job2 in the same cycle as exp_done
    base = eng_jobs;
    start_go(tbl[0].g, tbl[0].p, tbl[0].a, tbl[0].b);
    n = 0;
    while (!(eng_jobs == base + 3 && exp_done) && n < 400) begin
      n++;
      tick();
    end
    chk("abort.reach_job2", 64'(n < 400), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.key_a", key_a, 32'd0);
    chk("abort.pub_b", pub_b, tbl[0].pb);
    chk("abort.busy", busy, 1'b0);
    chk("abort.start", exp_start, 1'b0);
    chk("abort.error", error, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done || exp_start) bad = 1'b1;
      tick();
    end
    chk("abort.idle", 64'(bad), 64'd0);
    start_go(tbl[0].g, tbl[0].p, tbl[0].a, tbl[0].b);
    wait_done_check("abort_recover", tbl[0].pa, tbl[0].pb, tbl[0].ka, tbl[0].kb, 1'b1);

    // Engine holds exp_done three cycles after exp_start drops
    eng_hold = 3;
    start_go(tbl[0].g, tbl[0].p, tbl[0].a, tbl[0].b);
    n = 0;
    while (exp_start && n < 100) begin
      n++;
      tick();
    end
    lo = 0;
    while (!exp_start && lo < 50) begin
      lo++;
      tick();
    end
    chk("hold.gap_cycles", 64'(lo), 64'd4);
    chk("hold.done_low_at_rise", exp_done, 1'b0);
    wait_done_check("hold", tbl[0].pa, tbl[0].pb, tbl[0].ka, tbl[0].kb, 1'b1);
    eng_hold = 0;

    // Asynchronous reset in the middle of job1
    base = eng_jobs;
    start_go(tbl[0].g, tbl[0].p, tbl[0].a, tbl[0].b);
    n = 0;
    while (eng_jobs != base + 2 && n < 400) begin
      n++;
      tick();
    end
    tick(); tick(); tick();
    chk("arst.mid_job1_pub_a", pub_a, tbl[0].pa);
    rst = 1'b0;
    #1;
    chk("arst.start", exp_start, 1'b0);
    chk("arst.busy", busy, 1'b0);
    chk("arst.pub_a", pub_a, 32'd0);
    chk("arst.exp_base", exp_base, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    start_go(tbl[0].g, tbl[0].p, tbl[0].a, tbl[0].b);
    wait_done_check("arst_recover", tbl[0].pa, tbl[0].pb, tbl[0].ka, tbl[0].kb, 1'b1);

    // Randomized exchanges against the reference model
    for (int i = 0; i < 12; i++) begin
      logic [31:0] rp;
      rp = (i < 6) ? 32'($urandom_range(2, 65535)) : $urandom;
      if (rp < 32'd2) rp = 32'd2;
      eng_lat  = $urandom_range(1, 12);
      eng_hold = $urandom_range(0, 3);
      run_model($sformatf("rnd%0d", i), $urandom, rp, $urandom, $urandom);
    end
    eng_hold = 0;
    eng_lat = 10;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dh_exchange_ctrl.md
Name: dh_exchange_ctrl

Overview:
Sequences one shared exponentiation engine through the four jobs of a Diffie-Hellman exchange:
- A = g^a mod p
- B = g^b mod p
- KA = B^a mod p
- KB = A^b mod p
It owns the engine's start/done handshake, reduces each engine result modulo p, checks KA == KB, and reports status to the system-level top. It sits between the top-level key-exchange interface and the exponentiation datapath.

Parameters:
- W, 32: width of g, p, a, b and of the reduced results.
- RW, 64: width of the engine's raw result bus.
- TIMEOUT, 4096: maximum cycles to wait for exp_done per job before flagging an error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- go  in  1  single-cycle request to start an exchange; sampled only in IDLE
- abort  in  1  abandon current exchange, return to IDLE
- g  in  W  generator
- p  in  W  modulus
- priv_a  in  W  Alice private exponent
- priv_b  in  W  Bob private exponent
- exp_start  out  1  engine start, level, held until exp_done
- exp_base  out  W  engine base operand
- exp_exponent  out  W  engine exponent operand
- exp_result  in  RW  engine raw result
- exp_done  in  1  engine completion, level
- pub_a  out  W  A = g^a mod p
- pub_b  out  W  B = g^b mod p
- key_a  out  W  KA
- key_b  out  W  KB
- match  out  1  key_a == key_b, valid with done
- busy  out  1  exchange in progress
- done  out  1  one-cycle pulse, exchange complete
- error  out  1  sticky until next accepted go; set on p==0 or timeout

Behaviour:
- Reset: all outputs 0, state IDLE, job index 0, timeout counter 0. Reset mid-exchange drops exp_start immediately (asynchronous).
- States: IDLE, RUN, GAP, FIN, ERR.
- IDLE:
  - On go=1: latch g, p, priv_a, priv_b; clear pub_a, pub_b, key_a, key_b, match, error; set job=0; busy=1.
  - If the latched p==0 (checked on the raw input p), go to ERR; otherwise go to RUN.
- Operand map:
  - job0: base=g, exponent=a
  - job1: base=g, exponent=b
  - job2: base=pub_b, exponent=a
  - job3: base=pub_a, exponent=b
  - exp_base and exp_exponent are registered, stable for the whole of RUN, and 0 outside RUN and GAP.
- RUN:
  - exp_start=1; timeout counter increments each cycle.
  - On exp_done=1: write (exp_result mod p) to the job's destination (pub_a, pub_b, key_a, key_b), clear the counter, drop exp_start next cycle, go to GAP.
  - If the counter reaches TIMEOUT-1 without exp_done: go to ERR.
- GAP:
  - exp_start=0; wait until exp_done==0 (minimum 1 cycle).
  - Then, if job==3, go to FIN; else job+1 and go to RUN.
- FIN: match=(key_a==key_b); done=1 for exactly one cycle; busy=0; go to IDLE.
- ERR: error=1, exp_start=0, busy=0; go to IDLE next cycle. No done pulse.
- abort: in any non-IDLE state, next cycle goes to IDLE with exp_start=0 and busy=0. Results are left partial, with no done and no error. abort has priority over exp_done in the same cycle.
- go while busy is ignored; go and abort together in IDLE are treated as abort.
- Arithmetic:
  - Reduction is exp_result (RW bits, unsigned) mod p, a W-bit result < p.
  - Keys are correct only if the engine result has not wrapped RW bits; this controller does not detect wrap.
- Exponent 0 is legal; the engine returns 1, so the stored value is 1 mod p (0 if p==1).
- Outputs pub_a, pub_b, key_a, key_b and match hold until the next accepted go.
- Latency: 1 (IDLE→RUN) + sum over jobs of (engine latency + GAP cycles) + 1 (FIN).

Test Plan:
- g=5, p=23, a=6, b=15, bench engine with 10-cycle latency → pub_a=8, pub_b=19, key_a=key_b=2, match=1, single done pulse, error=0.
- p=0 with go → error=1 two cycles after go, exp_start never asserted, no done; next go with p=23 clears error.
- Engine never asserts exp_done, TIMEOUT=16 → exp_start drops and error=1 after 16 RUN cycles; busy=0.
- abort asserted during job2 RUN, same cycle as exp_done → key_a stays 0, IDLE next cycle, no done; a new go runs the full exchange correctly.
- Engine holds exp_done high 3 cycles after exp_start drops → controller stays in GAP until exp_done falls, and job1 exp_start rises only after that.
- rst asserted mid-job1 → all outputs 0 asynchronously; go after release yields the same results as the first scenario.
